// File: rtl/req_arb8_if.sv
// Request/grant bundle between the sources/consumer and the req_arb8 arbiter.
interface req_arb8_if #(
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = 3
);
   logic [N-1:0]     req_in;
   logic             en;
   logic             gnt_ack;
   logic [N-1:0]     gnt;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;
   logic [N-1:0]     pending;
   logic             req_up;

   // Requesters and grant consumer side.
   modport master (
      output req_in, en, gnt_ack,
      input  gnt, gnt_valid, gnt_idx, pending, req_up
   );

   // Arbiter side.
   modport slave (
      input  req_in, en, gnt_ack,
      output gnt, gnt_valid, gnt_idx, pending, req_up
   );
endinterface

// File: rtl/req_arb8.sv
// Rotating-priority request arbiter: sticky pending requests, registered one-hot
// grant held until acknowledged. Out of reset the highest index has top priority.
module req_arb8 #(
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = 3
) (
   input logic       i_clock,
   input logic       i_reset,
   req_arb8_if.slave io_bus
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e           r_state;
   logic [N-1:0]     r_pending;
   logic [N-1:0]     r_gnt;
   logic             r_gnt_valid;
   logic [IDX_W-1:0] r_gnt_idx;
   logic [IDX_W-1:0] r_ptr;

   logic             w_ack;
   logic [N-1:0]     w_clr;
   logic [N-1:0]     w_cand;
   logic [N-1:0]     w_pending_next;
   logic [IDX_W-1:0] w_search_ptr;
   logic [IDX_W-1:0] w_win_idx;
   logic             w_win_found;

   // Acknowledge handling, pending next-state and rotating descending search.
   always_comb begin
      logic [IDX_W-1:0] v_idx;
      w_ack          = r_gnt_valid & io_bus.gnt_ack;
      w_clr          = w_ack ? (N'(1) << r_gnt_idx) : '0;
      // The search sees the cleared vector only; fresh req_in waits one edge.
      w_cand         = r_pending & ~w_clr;
      w_pending_next = w_cand | io_bus.req_in;
      // On ack the just-served index drops to lowest priority in this same cycle.
      w_search_ptr   = w_ack ? (r_gnt_idx - IDX_W'(1)) : r_ptr;
      w_win_found    = 1'b0;
      w_win_idx      = '0;
      v_idx          = '0;
      for (int unsigned i = 0; i < N; i++) begin
         v_idx = w_search_ptr - IDX_W'(i);
         if (!w_win_found && w_cand[v_idx]) begin
            w_win_found = 1'b1;
            w_win_idx   = v_idx;
         end
      end
   end

   // Grant FSM with registered outputs, pointer and pending vector.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= StIdle;
         r_pending   <= '0;
         r_gnt       <= '0;
         r_gnt_valid <= 1'b0;
         r_gnt_idx   <= '0;
         r_ptr       <= IDX_W'(N - 1);
      end else begin
         r_pending <= w_pending_next;
         unique case (r_state)
            StIdle: begin
               if (io_bus.en && w_win_found) begin
                  r_gnt       <= N'(1) << w_win_idx;
                  r_gnt_idx   <= w_win_idx;
                  r_gnt_valid <= 1'b1;
                  r_state     <= StGrant;
               end else begin
                  r_gnt       <= '0;
                  r_gnt_idx   <= '0;
                  r_gnt_valid <= 1'b0;
               end
            end
            StGrant: begin
               if (w_ack) begin
                  r_ptr <= w_search_ptr;
                  if (io_bus.en && w_win_found) begin
                     r_gnt     <= N'(1) << w_win_idx;
                     r_gnt_idx <= w_win_idx;
                  end else begin
                     r_gnt       <= '0;
                     r_gnt_idx   <= '0;
                     r_gnt_valid <= 1'b0;
                     r_state     <= StIdle;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_bus.gnt       = r_gnt;
   assign io_bus.gnt_valid = r_gnt_valid;
   assign io_bus.gnt_idx   = r_gnt_idx;
   assign io_bus.pending   = r_pending;
   assign io_bus.req_up    = |r_pending;

endmodule

// File: doc/req_arb8.md
Name: req_arb8

Overview:
- Sequential request arbiter placed directly upstream of the 8-bit priority select stage.
- Accumulates sticky request pulses from 8 sources and chooses one with a rotating-priority search, so no source can starve.
- Issues a registered one-hot grant and holds it until the downstream consumer acknowledges it.
- Default priority out of reset is highest index first, matching the fixed-priority selector convention (req[7] beats req[0]).

Parameters:
- N, 8, number of requesters; fixed at 8 for this revision.
- IDX_W, 3, width of grant index and priority pointer; equals log2(N).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_in  input  8  request pulses; each set bit sets pending[i] on the next edge.
- en  input  1  arbitration enable; when low, no new grant is issued.
- gnt_ack  input  1  consumer has finished with the current grant.
- gnt  output  8  registered one-hot grant; all zero when no grant is active.
- gnt_valid  output  1  high while gnt is non-zero.
- gnt_idx  output  3  binary index of the granted bit; 0 when gnt_valid is low.
- pending  output  8  registered sticky request vector.
- req_up  output  1  OR of pending (combinational from the register); feeds an upper-level selector.

Behaviour:
- Reset, synchronous: pending=0, gnt=0, gnt_valid=0, gnt_idx=0, ptr=7, state=IDLE. A reset mid-grant drops the grant and discards all pending requests on that edge.
- Pending update each edge: pending_next = (pending & ~clr) | req_in.
  - clr is one-hot of gnt_idx when gnt_valid & gnt_ack, otherwise zero.
  - Set wins: a req_in[k] in the same cycle as an ack of k leaves pending[k]=1.
- Search order: ptr, ptr-1, …, 0, 7, …, ptr+1 (mod-8 descending). The first set bit of the candidate vector wins.
- Candidate vector: pending_next is NOT used for the search; use cand = pending & ~clr.
  - Consequence: a request arriving in cycle t is first eligible at edge t+1 and grants no earlier than edge t+2 (2-cycle req_in-to-gnt latency).
- States: IDLE, GRANT.
  - IDLE:
    - If en and cand!=0: load gnt/gnt_idx with the winner k, set gnt_valid=1, move to GRANT.
    - Otherwise stay in IDLE with gnt=0.
  - GRANT:
    - gnt is held stable while gnt_ack=0, regardless of en or new req_in.
    - On gnt_ack=1, pointer update: ptr <= (k-1) mod 8, so k becomes lowest priority. Wrap: k=0 gives ptr=7.
    - On gnt_ack=1, next grant: the search runs on cand with the new pointer value in the same cycle.
      - If en and cand!=0: grant the next winner on the following edge (back-to-back, stay in GRANT).
      - Otherwise: gnt=0, go to IDLE.
- gnt_ack while in IDLE is ignored; it causes no clear and no pointer change.
- Invariants (checkable as assertions):
  - gnt has at most one bit set.
  - gnt_valid == |gnt.
  - gnt[gnt_idx]==1 whenever gnt_valid.
  - A granted bit is always set in pending.
- en low during GRANT: the grant is held until ack and not re-armed afterwards; pending keeps accumulating.
- All 8 requests pending, ack every cycle: grants run 7,6,5,…,0,7 — each source served once per 8 grants.

Test Plan:
- Reset, then req_in=8'h81 for one cycle, en=1 → pending=8'h81 after 1 edge; gnt=8'h80, gnt_idx=7 after the 2nd edge; req_up=1.
- Hold the grant of index 7, ack after 3 cycles → gnt stable for 3 cycles; next edge gnt=8'h01, ptr=6, pending=8'h01; ack again → gnt=0, IDLE, pending=0, req_up=0.
- req_in=8'hFF once, gnt_ack tied high → grant sequence 80,40,20,10,08,04,02,01 on consecutive edges, then gnt=0.
- Source 3 re-requests on the cycle of its own ack (pending=8'h08, ack with req_in=8'h08) → pending stays 8'h08, ptr=2, source 3 re-granted only after other pending sources in the search order.
- en=0 with req_in=8'h10 → no grant, pending=8'h10 held; raise en → gnt=8'h10 on the next edge.
- Assert reset while gnt=8'h04 with pending=8'h0C → next edge gnt=0, gnt_valid=0, pending=0, ptr=7; after release, req_in=8'h04 is granted normally.
